// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational Alu between execute (port 0) and address-gen (port 1).
// Optional performance counters are enabled by defining ALU_ARB_PERF_CNT_EN.
module alu_arbiter #(
  parameter int WORD_WIDTH  = 32,
  parameter int OPER_WIDTH  = 5,
  parameter int FLAGS_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [OPER_WIDTH-1:0]  req0_oper,
  input  logic [WORD_WIDTH-1:0]  req0_a,
  input  logic [WORD_WIDTH-1:0]  req0_b,
  input  logic [WORD_WIDTH-1:0]  req0_c,
  input  logic                   req0_wr_flags,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [OPER_WIDTH-1:0]  req1_oper,
  input  logic [WORD_WIDTH-1:0]  req1_a,
  input  logic [WORD_WIDTH-1:0]  req1_b,
  input  logic [WORD_WIDTH-1:0]  req1_c,
  output logic [WORD_WIDTH-1:0]  alu_a,
  output logic [WORD_WIDTH-1:0]  alu_b,
  output logic [WORD_WIDTH-1:0]  alu_c,
  output logic [OPER_WIDTH-1:0]  alu_oper,
  output logic [FLAGS_WIDTH-1:0] alu_flags_in,
  input  logic [WORD_WIDTH-1:0]  alu_out,
  input  logic [FLAGS_WIDTH-1:0] alu_flags_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [WORD_WIDTH-1:0]  rsp_data,
  output logic [FLAGS_WIDTH-1:0] rsp_flags,
`ifdef ALU_ARB_PERF_CNT_EN
  output logic [FLAGS_WIDTH-1:0] flags_q,
  output logic [31:0]            perf_grant0,
  output logic [31:0]            perf_grant1,
  output logic [31:0]            perf_conflict
`else
  output logic [FLAGS_WIDTH-1:0] flags_q
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]            state;
  logic                  last_grant;
  logic                  grant;
  logic                  accept;
  logic                  iss_id;
  logic                  iss_wr_flags;
  logic [OPER_WIDTH-1:0] iss_oper;
  logic [WORD_WIDTH-1:0] iss_a;
  logic [WORD_WIDTH-1:0] iss_b;
  logic [WORD_WIDTH-1:0] iss_c;

  // On a tie the port that did not win last time gets the Alu.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;

  // Issue registers only change on accept, so the Alu inputs stay quiet outside EXEC.
  assign alu_a        = iss_a;
  assign alu_b        = iss_b;
  assign alu_c        = iss_c;
  assign alu_oper     = iss_oper;
  assign alu_flags_in = flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      iss_id       <= 1'b0;
      iss_wr_flags <= 1'b0;
      iss_oper     <= '0;
      iss_a        <= '0;
      iss_b        <= '0;
      iss_c        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      rsp_flags    <= '0;
      flags_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= EXEC;
            last_grant   <= grant;
            iss_id       <= grant;
            iss_wr_flags <= !grant && req0_wr_flags;
            iss_oper     <= grant ? req1_oper : req0_oper;
            iss_a        <= grant ? req1_a : req0_a;
            iss_b        <= grant ? req1_b : req0_b;
            iss_c        <= grant ? req1_c : req0_c;
          end
        end
        EXEC: begin
          state     <= HOLD;
          rsp_valid <= 1'b1;
          rsp_id    <= iss_id;
          rsp_data  <= alu_out;
          rsp_flags <= alu_flags_out;
          if (iss_wr_flags) begin
            flags_q <= alu_flags_out;
          end
        end
        HOLD: begin
          if (rsp_valid && rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      if (req0_valid && req0_ready) begin
        perf_grant0 <= perf_grant0 + 32'd1;
      end
      if (req1_valid && req1_ready) begin
        perf_grant1 <= perf_grant1 + 32'd1;
      end
      if ((state == IDLE) && req0_valid && req1_valid) begin
        perf_conflict <= perf_conflict + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a small Alu stand-in drives the Alu side, and a
// transaction-level model predicts grants, responses, flags and (optionally) perf counters.
module tb_alu_arbiter;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADC  = 5'd1;
  localparam logic [4:0] OP_ADD3 = 5'd2;
  localparam int F_C = 0;
  localparam int F_Z = 1;
  localparam int F_N = 2;
  localparam int F_V = 3;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_wr_flags;
  logic [4:0]  req0_oper;
  logic [31:0] req0_a, req0_b, req0_c;
  logic        req1_valid, req1_ready;
  logic [4:0]  req1_oper;
  logic [31:0] req1_a, req1_b, req1_c;
  logic [31:0] alu_a, alu_b, alu_c, alu_out;
  logic [4:0]  alu_oper;
  logic [3:0]  alu_flags_in, alu_flags_out;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags, flags_q;
`ifdef ALU_ARB_PERF_CNT_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: committed flags, last accepted port, accept/conflict counts.
  logic [3:0] m_flags;
  logic       m_last;
  int         m_g0, m_g1, m_conf;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_oper(req0_oper),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c), .req0_wr_flags(req0_wr_flags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_oper(req1_oper),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_oper(alu_oper),
    .alu_flags_in(alu_flags_in), .alu_out(alu_out), .alu_flags_out(alu_flags_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
`ifdef ALU_ARB_PERF_CNT_EN
    .flags_q(flags_q),
    .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
`else
    .flags_q(flags_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Alu stand-in: add/adc/add-three with C/Z/N/V, anything else is a recognisable mix.
  function automatic logic [35:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c,
                                         input logic [3:0] fin);
    logic [33:0] s;
    logic [31:0] r;
    logic [3:0]  f;
    s = 34'd0;
    r = 32'd0;
    f = 4'd0;
    case (op)
      OP_ADD:  s = {2'b0, a} + {2'b0, b};
      OP_ADC:  s = {2'b0, a} + {2'b0, b} + {33'd0, fin[F_C]};
      OP_ADD3: s = {2'b0, a} + {2'b0, b} + {2'b0, c};
      default: s = 34'd0;
    endcase
    if (op <= OP_ADD3) begin
      r      = s[31:0];
      f[F_C] = |s[33:32];
      f[F_Z] = (r == 32'd0);
      f[F_N] = r[31];
      f[F_V] = (op != OP_ADD3) && (a[31] == b[31]) && (r[31] != a[31]);
    end else begin
      r = a ^ b ^ c ^ {27'd0, op};
      f = op[3:0];
    end
    return {f, r};
  endfunction

  always_comb {alu_flags_out, alu_out} = alu_fn(alu_oper, alu_a, alu_b, alu_c, alu_flags_in);

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_flags = 4'd0;
    m_last  = 1'b1;
    m_g0    = 0;
    m_g1    = 0;
    m_conf  = 0;
  endtask

  task automatic setReq(input bit port, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input bit wr, input bit v);
    if (port == 1'b0) begin
      req0_valid = v; req0_oper = op; req0_a = a; req0_b = b; req0_c = c; req0_wr_flags = wr;
    end else begin
      req1_valid = v; req1_oper = op; req1_a = a; req1_b = b; req1_c = c;
    end
  endtask

  // One lone request: accept, check latency and response, optionally stall rsp_ready.
  task automatic applyStimulus(input bit port, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] c, input bit wr,
                               input int hold);
    logic [35:0] e;
    logic [3:0]  next_flags;
    int          n;
    e          = alu_fn(op, a, b, c, m_flags);
    next_flags = (port == 1'b0 && wr) ? e[35:32] : m_flags;
    @(negedge clk);
    setReq(port, op, a, b, c, wr, 1'b1);
    #1;
    n = 0;
    while (!(port ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_timeout", 64'(n >= 20), 64'd0);
    @(posedge clk);
    #1;
    setReq(port, op, a, b, c, wr, 1'b0);
    m_last = port;
    if (port) m_g1++; else m_g0++;
    @(negedge clk);
    checkOutput("exec_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    checkOutput("rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("rsp_id", 64'(rsp_id), 64'(port));
    checkOutput("rsp_data", 64'(rsp_data), 64'(e[31:0]));
    checkOutput("rsp_flags", 64'(rsp_flags), 64'(e[35:32]));
    checkOutput("flags_q", 64'(flags_q), 64'(next_flags));
    m_flags = next_flags;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("hold_rsp_data", 64'({rsp_valid, rsp_data}), 64'({1'b1, e[31:0]}));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic checkPerf();
`ifdef ALU_ARB_PERF_CNT_EN
    checkOutput("perf_grant0", 64'(perf_grant0), 64'(m_g0));
    checkOutput("perf_grant1", 64'(perf_grant1), 64'(m_g1));
    checkOutput("perf_conflict", 64'(perf_conflict), 64'(m_conf));
`endif
  endtask

  initial begin
    int          n;
    bit          g;
    bit          exp_g;
    logic [4:0]  rop;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    setReq(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    setReq(1'b1, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    modelReset();
    #12;
    checkOutput("reset_rsp", 64'({rsp_valid, rsp_id, rsp_flags, rsp_data}), 64'd0);
    checkOutput("reset_flags_q", 64'(flags_q), 64'd0);
    checkOutput("reset_alu", 64'({alu_oper, alu_a}), 64'd0);
    checkOutput("reset_alu_flags_in", 64'(alu_flags_in), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single port 0 add");
    applyStimulus(1'b0, OP_ADD, 32'd5, 32'd7, 32'd0, 1'b1, 0);
    $display("[TB] carry chain");
    applyStimulus(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 0);
    applyStimulus(1'b0, OP_ADC, 32'd0, 32'd0, 32'd0, 1'b0, 0);
    $display("[TB] port 1 flags isolation");
    applyStimulus(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);

    $display("[TB] contention");
    rsp_ready = 1'b1;
    @(negedge clk);
    setReq(1'b0, OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1);
    setReq(1'b1, OP_ADD, 32'd10, 32'd20, 32'd0, 1'b0, 1'b1);
    #1;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 10) begin
        @(negedge clk);
        n++;
      end
      checkOutput("contention_timeout", 64'(n >= 10), 64'd0);
      checkOutput("both_ready", 64'(req0_ready && req1_ready), 64'd0);
      g     = req1_ready;
      exp_g = ~m_last;
      checkOutput("grant_order", 64'(g), 64'(exp_g));
      m_last = exp_g;
      if (exp_g) m_g1++; else m_g0++;
      m_conf++;
      @(posedge clk);
      #1;
      if (k == 5) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
      checkOutput("cont_exec_valid", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      checkOutput("cont_rsp_id", 64'({rsp_valid, rsp_id}), 64'({1'b1, exp_g}));
      checkOutput("cont_rsp_data", 64'(rsp_data), exp_g ? 64'd30 : 64'd3);
      @(negedge clk);
      #1;
    end
    rsp_ready = 1'b0;

    $display("[TB] backpressure");
    @(negedge clk);
    setReq(1'b0, OP_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1);
    #1;
    checkOutput("bp_ready0", 64'(req0_ready), 64'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    m_last = 1'b0;
    m_g0++;
    setReq(1'b1, OP_ADD, 32'd100, 32'd200, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("bp_exec_ready1", 64'(req1_ready), 64'd0);
    for (int h = 0; h < 6; h++) begin
      @(negedge clk);
      checkOutput("bp_hold_rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'({1'b1, 1'b0, 32'd7}));
      checkOutput("bp_hold_ready", 64'({req0_ready, req1_ready}), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_idle_ready1", 64'(req1_ready), 64'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    m_last = 1'b1;
    m_g1++;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_second_rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'({1'b1, 1'b1, 32'd300}));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;

    $display("[TB] randomized ops");
    for (int r = 0; r < 24; r++) begin
      case ($urandom_range(0, 3))
        0: rop = OP_ADD;
        1: rop = OP_ADC;
        2: rop = OP_ADD3;
        default: rop = 5'($urandom_range(0, 31));
      endcase
      applyStimulus(1'($urandom_range(0, 1)), rop, $urandom, $urandom, $urandom,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
    checkPerf();

    $display("[TB] reset during EXEC");
    applyStimulus(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 0);
    @(negedge clk);
    setReq(1'b0, OP_ADD, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1);
    #1;
    checkOutput("rst_pre_ready0", 64'(req0_ready), 64'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_flags_q", 64'({alu_flags_in, flags_q}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int h = 0; h < 6; h++) begin
      @(negedge clk);
      checkOutput("rst_no_stale_rsp", 64'(rsp_valid), 64'd0);
    end
    checkPerf();
    applyStimulus(1'b0, OP_ADD, 32'd9, 32'd1, 32'd0, 1'b1, 0);
    checkPerf();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
